cdma_gold_mc: RTL and testbench

Parametrised multi-channel Gold-code CDMA transceiver, the next generation of the single-channel `cdma` core. It spreads N_CH user data streams, each with its own Gold code built from two LFSR_W-bit m-sequence generators. It outputs per-channel chips and their bipolar sum, and despreads one selectable channel from a single received chip stream with a thresholded correlator. A one-entry holding buffer with valid/ready handshake feeds the transmit side.

---
 rtl/cdma_gold_mc.sv | 179 +++++++++++++++++
 tb/tb_cdma_gold_mc.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdma_gold_mc.sv
// Multi-channel Gold-code CDMA transceiver: per-channel spreading from a shared
// generator A and per-channel generators B, plus a thresholded one-channel despreader.
module cdma_gold_mc #(
    parameter int unsigned       LFSR_W   = 5,
    parameter logic [LFSR_W-1:0] POLY_A   = 5'h12,
    parameter logic [LFSR_W-1:0] POLY_B   = 5'h1E,
    parameter int unsigned       N_CH     = 2,
    parameter int unsigned       CHIP_DIV = 4,
    parameter int unsigned       THRESH   = 24,
    localparam int unsigned      SUM_W    = $clog2(N_CH + 1) + 1,
    localparam int unsigned      SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_CH*LFSR_W-1:0]   seed_i,
    input  logic [N_CH-1:0]          tx_data_i,
    input  logic                     tx_valid_i,
    output logic                     tx_ready_o,
    output logic                     tx_underrun_o,
    output logic [N_CH-1:0]          chip_o,
    output logic [N_CH-1:0]          gold_o,
    output logic signed [SUM_W-1:0]  cdma_sum_o,
    input  logic                     rx_chip_i,
    input  logic [SEL_W-1:0]         rx_sel_i,
    output logic                     rx_bit_o,
    output logic                     rx_valid_o,
    output logic                     rx_err_o
);

    localparam int unsigned L     = (1 << LFSR_W) - 1;
    localparam int unsigned DIV_W = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam int unsigned M_W   = LFSR_W + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CHIP_DIV - 1);
    localparam logic [LFSR_W-1:0] IDX_LAST = LFSR_W'(L - 1);
    localparam logic [M_W-1:0]    M_HI     = M_W'(THRESH);
    localparam logic [M_W-1:0]    M_LO     = M_W'(L - THRESH);
    localparam logic [LFSR_W-1:0] ONES     = '1;

    logic [DIV_W-1:0]  div_cnt;
    logic [LFSR_W-1:0] chip_idx;
    logic              chip_stb;
    logic              bit_stb;

    logic [LFSR_W-1:0] a_q;
    logic [LFSR_W-1:0] b_q [N_CH];

    logic [N_CH-1:0]   hold_q;
    logic [N_CH-1:0]   active_q;
    logic              hold_full;
    logic              underrun_q;

    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  sel_next;
    logic [31:0]       sel_ext;
    logic [M_W-1:0]    m_cnt;
    logic [M_W-1:0]    m_sum;
    logic              match;
    logic              rx_bit_q;
    logic              rx_valid_q;
    logic              rx_err_q;

    logic signed [SUM_W-1:0] sum_c;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                    input logic [LFSR_W-1:0] poly);
        return (s >> 1) ^ (s[0] ? poly : '0);
    endfunction

    assign chip_stb = (div_cnt == DIV_LAST);
    assign bit_stb  = chip_stb && (chip_idx == IDX_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt  <= '0;
            chip_idx <= '0;
        end else begin
            div_cnt <= chip_stb ? '0 : div_cnt + DIV_W'(1);
            if (chip_stb)
                chip_idx <= bit_stb ? '0 : chip_idx + LFSR_W'(1);
        end
    end

    // Every bit restarts all generators at code phase 0; new seeds land only here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q <= ONES;
            for (int i = 0; i < N_CH; i++)
                b_q[i] <= ONES;
        end else if (chip_stb) begin
            a_q <= bit_stb ? ONES : lfsr_step(a_q, POLY_A);
            for (int i = 0; i < N_CH; i++)
                b_q[i] <= bit_stb ? seed_i[i*LFSR_W +: LFSR_W] : lfsr_step(b_q[i], POLY_B);
        end
    end

    always_comb begin
        gold_o = '0;
        for (int i = 0; i < N_CH; i++)
            gold_o[i] = a_q[0] ^ b_q[i][0];
    end

    assign chip_o = active_q ^ gold_o;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < N_CH; i++)
            sum_c = chip_o[i] ? sum_c + SUM_W'(1) : sum_c - SUM_W'(1);
    end

    assign cdma_sum_o = sum_c;

    // An accept coinciding with an empty-buffer bit boundary still reports underrun.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q     <= '0;
            active_q   <= '0;
            hold_full  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (bit_stb) begin
                if (hold_full) begin
                    active_q  <= hold_q;
                    hold_full <= 1'b0;
                end else begin
                    active_q   <= '0;
                    underrun_q <= 1'b1;
                end
            end
            if (tx_valid_i && !hold_full) begin
                hold_q    <= tx_data_i;
                hold_full <= 1'b1;
            end
        end
    end

    assign tx_ready_o    = ~hold_full;
    assign tx_underrun_o = underrun_q;

    assign sel_ext  = 32'(rx_sel_i);
    assign sel_next = (sel_ext < N_CH) ? rx_sel_i : '0;
    assign match    = ~(rx_chip_i ^ gold_o[sel_q]);
    assign m_sum    = m_cnt + M_W'(match);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q      <= '0;
            m_cnt      <= '0;
            rx_bit_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (bit_stb) begin
                rx_valid_q <= 1'b1;
                m_cnt      <= '0;
                sel_q      <= sel_next;
                if (m_sum >= M_HI) begin
                    rx_bit_q <= 1'b0;
                    rx_err_q <= 1'b0;
                end else if (m_sum <= M_LO) begin
                    rx_bit_q <= 1'b1;
                    rx_err_q <= 1'b0;
                end else begin
                    rx_bit_q <= 1'b0;
                    rx_err_q <= 1'b1;
                end
            end else if (chip_stb) begin
                m_cnt <= m_sum;
            end
        end
    end

    assign rx_bit_o   = rx_bit_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_err_o   = rx_err_q;

endmodule

// File: tb/tb_cdma_gold_mc.sv
// Bench for cdma_gold_mc: loopback scoreboard on a 2-channel instance and a
// bit-boundary handshake corner on a 4-channel, one-cycle-per-chip instance.
module tb_cdma_gold_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: defaults (N_CH = 2, CHIP_DIV = 4, period 124 cycles).
    logic              rst = 1'b0;
    logic [9:0]        seed = '0;
    logic [1:0]        tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic              tx_underrun;
    logic [1:0]        chip;
    logic [1:0]        gold;
    logic signed [2:0] cdma_sum;
    logic              rx_chip = 1'b0;
    logic [0:0]        rx_sel = '0;
    logic              rx_bit;
    logic              rx_valid;
    logic              rx_err;

    cdma_gold_mc dut (
        .clk_i(clk), .rst_i(rst), .seed_i(seed), .tx_data_i(tx_data),
        .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_underrun_o(tx_underrun),
        .chip_o(chip), .gold_o(gold), .cdma_sum_o(cdma_sum), .rx_chip_i(rx_chip),
        .rx_sel_i(rx_sel), .rx_bit_o(rx_bit), .rx_valid_o(rx_valid), .rx_err_o(rx_err)
    );

    // Corner instance: four channels, one cycle per chip (period 31 cycles).
    logic              rst4 = 1'b0;
    logic [19:0]       seed4 = '0;
    logic [3:0]        tx_data4 = '0;
    logic              tx_valid4 = 1'b0;
    logic              tx_ready4;
    logic              tx_underrun4;
    logic [3:0]        chip4;
    logic [3:0]        gold4;
    logic signed [3:0] cdma_sum4;
    logic              rx_chip4 = 1'b0;
    logic [1:0]        rx_sel4 = '0;
    logic              rx_bit4;
    logic              rx_valid4;
    logic              rx_err4;

    cdma_gold_mc #(.N_CH(4), .CHIP_DIV(1)) dut4 (
        .clk_i(clk), .rst_i(rst4), .seed_i(seed4), .tx_data_i(tx_data4),
        .tx_valid_i(tx_valid4), .tx_ready_o(tx_ready4), .tx_underrun_o(tx_underrun4),
        .chip_o(chip4), .gold_o(gold4), .cdma_sum_o(cdma_sum4), .rx_chip_i(rx_chip4),
        .rx_sel_i(rx_sel4), .rx_bit_o(rx_bit4), .rx_valid_o(rx_valid4), .rx_err_o(rx_err4)
    );

    int total = 0;
    int bad = 0;

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference code generator: Galois right shift, output taken before the step.
    function automatic logic [30:0] seqBits(input logic [4:0] start, input logic [4:0] poly);
        logic [4:0]  s;
        logic [30:0] r;
        s = start;
        r = '0;
        for (int j = 0; j < 31; j++) begin
            r[j] = s[0];
            s = (s >> 1) ^ (s[0] ? poly : 5'h00);
        end
        return r;
    endfunction

    function automatic logic [30:0] goldSeq(input logic [4:0] seedv);
        return seqBits(5'h1F, 5'h12) ^ seqBits(seedv, 5'h1E);
    endfunction

    // Per-period plan for the main instance: data offered during period p is sent in p+1.
    int         send_plan  [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 0};
    logic [1:0] data_plan  [10] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b00,
                                    2'b10, 2'b11, 2'b10, 2'b00, 2'b00};
    int         noise_plan [10] = '{0, 0, 5, 5, 10, 0, 10, 0, 0, 0};

    function automatic logic [1:0] activeFor(input int p);
        if (p == 0 || send_plan[p-1] == 0) return 2'b00;
        return data_plan[p-1];
    endfunction

    function automatic logic [4:0] seedFor(input int p, input int ch);
        if (p == 0) return 5'h1F;
        if (ch == 0) return (p >= 7) ? 5'h00 : 5'h01;
        return 5'h15;
    endfunction

    // Expected {rx_bit, rx_err} for period p of the channel-1 loopback.
    function automatic logic [1:0] rxExpect(input int p);
        logic [1:0] a;
        int m;
        a = activeFor(p);
        m = a[1] ? noise_plan[p] : 31 - noise_plan[p];
        if (m >= 24) return 2'b00;
        if (m <= 7)  return 2'b10;
        return 2'b01;
    endfunction

    int         cyc = 0;
    int         next_due = 124;
    int         rx_count = 0;
    bit         main_active = 1'b0;
    logic [1:0] sb_q [$];

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin : loopDrive
        int p;
        int pos;
        p   = cyc / 124;
        pos = (cyc % 124) / 4;
        rx_chip = chip[1] ^ (p < 10 && pos < noise_plan[p]);
    end

    always @(negedge clk) begin : rxMonitor
        logic [1:0] e;
        if (rst) begin
            next_due = 124;
        end else if (rx_valid) begin
            checkOutput("rx_valid_time", cyc, next_due);
            next_due += 124;
            rx_count++;
            if (sb_q.size() == 0) begin
                checkOutput("rx_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                checkOutput($sformatf("rx_bit n%0d", rx_count), rx_bit, e[1]);
                checkOutput($sformatf("rx_err n%0d", rx_count), rx_err, e[0]);
            end
        end
    end

    always @(negedge clk) begin : chipMonitor
        int p;
        int j;
        int es;
        logic [1:0] eg;
        logic [1:0] ec;
        if (!rst && main_active && (cyc % 4) == 3) begin
            p = cyc / 124;
            j = (cyc % 124) / 4;
            for (int ch = 0; ch < 2; ch++) begin
                logic [30:0] gs;
                gs = goldSeq(seedFor(p, ch));
                eg[ch] = gs[j];
            end
            ec = eg ^ activeFor(p);
            es = 0;
            for (int ch = 0; ch < 2; ch++) es += ec[ch] ? 1 : -1;
            checkOutput($sformatf("gold p%0d c%0d", p, j), gold, eg);
            checkOutput($sformatf("chip p%0d c%0d", p, j), chip, ec);
            checkOutput($sformatf("sum p%0d c%0d", p, j), cdma_sum, es);
        end
    end

    task automatic waitCycle(input int target);
        int guard;
        guard = 0;
        while (cyc != target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != target) checkOutput("wait_cycle", cyc, target);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " tx_ready"}, tx_ready, 1);
        checkOutput({tag, " underrun"}, tx_underrun, 0);
        checkOutput({tag, " rx_bit"}, rx_bit, 0);
        checkOutput({tag, " rx_valid"}, rx_valid, 0);
        checkOutput({tag, " rx_err"}, rx_err, 0);
        checkOutput({tag, " gold"}, gold, 0);
        checkOutput({tag, " chip"}, chip, 0);
        checkOutput({tag, " sum"}, cdma_sum, -2);
    endtask

    task automatic applyStimulus(input int p);
        waitCycle(p * 124);
        checkOutput($sformatf("ready_start p%0d", p), tx_ready, 1);
        checkOutput($sformatf("underrun_start p%0d", p), tx_underrun,
                    (p > 0 && send_plan[p-1] == 0) ? 1 : 0);
        if (p == 6) seed[4:0] = 5'h00;
        if (p + 1 <= 8) sb_q.push_back(rxExpect(p + 1));
        if (send_plan[p] != 0) begin
            tx_valid = 1'b1;
            tx_data  = data_plan[p];
            @(negedge clk);
            checkOutput($sformatf("ready_after_accept p%0d", p), tx_ready, 0);
            tx_valid = 1'b0;
        end
        waitCycle(p * 124 + 1);
        checkOutput($sformatf("underrun_one_cycle p%0d", p), tx_underrun, 0);
        waitCycle(p * 124 + 123);
        checkOutput($sformatf("ready_end p%0d", p), tx_ready, send_plan[p] == 0 ? 1 : 0);
    endtask

    task automatic runMain();
        seed     = {5'h15, 5'h01};
        rx_sel   = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkResetValues("rst0");
        rst = 1'b0;
        main_active = 1'b1;
        sb_q.push_back(rxExpect(0));
        for (int p = 0; p < 9; p++) applyStimulus(p);

        waitCycle(9 * 124);
        checkOutput("ready_start p9", tx_ready, 1);
        checkOutput("underrun_start p9", tx_underrun, 1);
        waitCycle(9 * 124 + 50);
        checkOutput("sb_drained", sb_q.size(), 0);
        checkOutput("rx_count", rx_count, 9);

        main_active = 1'b0;
        rst = 1'b1;
        #1;
        checkResetValues("rst_mid");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        main_active = 1'b1;
        sb_q.push_back(rxExpect(0));
        for (int k = 0; k < 300 && sb_q.size() != 0; k++) @(negedge clk);
        checkOutput("restart_drained", sb_q.size(), 0);
        checkOutput("restart_rx_count", rx_count, 10);
        main_active = 1'b0;
    endtask

    task automatic runCorner();
        logic [3:0] eg;
        logic [3:0] ec;
        int es;
        int s;
        int p;
        int j;
        seed4 = {5'h00, 5'h07, 5'h15, 5'h01};
        @(negedge clk);
        rst4 = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("c_ready_rst", tx_ready4, 1);
        checkOutput("c_sum_rst", cdma_sum4, -4);
        rst4 = 1'b0;
        for (int c = 0; c < 93; c++) begin
            p = c / 31;
            j = c % 31;
            for (int ch = 0; ch < 4; ch++) begin
                logic [30:0] gs;
                gs = goldSeq((p == 0) ? 5'h1F : seed4[ch*5 +: 5]);
                eg[ch] = gs[j];
            end
            ec = eg ^ ((p == 2) ? 4'b1011 : 4'b0000);
            es = 0;
            for (int ch = 0; ch < 4; ch++) es += ec[ch] ? 1 : -1;
            s = cdma_sum4;
            checkOutput($sformatf("c_gold p%0d c%0d", p, j), gold4, eg);
            checkOutput($sformatf("c_chip p%0d c%0d", p, j), chip4, ec);
            checkOutput($sformatf("c_sum p%0d c%0d", p, j), s, es);
            checkOutput($sformatf("c_sum_range p%0d c%0d", p, j), (s >= -4 && s <= 4) ? 1 : 0, 1);
            if (c == 30) begin
                checkOutput("c_ready_at_boundary", tx_ready4, 1);
                tx_valid4 = 1'b1;
                tx_data4  = 4'b1011;
            end
            if (c == 31) begin
                checkOutput("c_underrun", tx_underrun4, 1);
                checkOutput("c_ready_after_accept", tx_ready4, 0);
                checkOutput("c_rx_valid p0", rx_valid4, 1);
                tx_valid4 = 1'b0;
            end
            if (c == 62) begin
                checkOutput("c_no_underrun", tx_underrun4, 0);
                checkOutput("c_ready_after_send", tx_ready4, 1);
                checkOutput("c_rx_valid p1", rx_valid4, 1);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        fork
            runMain();
            runCorner();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
